// File: rtl/riscv_pkg.sv
// Shared pre-decode definitions: canonical NOP encoding and the decode-queue entry layout.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PD_XLEN   = 32;
  localparam int          PD_META_W = 64;

  typedef struct packed {
    logic [31:0]          instruction;
    logic [PD_XLEN-1:0]   pc;
    logic [PD_XLEN-1:0]   link_address;
    logic                 illegal;
    logic [PD_META_W-1:0] meta;
  } pd_queue_entry_t;

endpackage

// File: rtl/pd_queue_fifo.sv
// Generic DEPTH-entry register FIFO with occupancy count and flush; entry type is a parameter.
module pd_queue_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = pd_queue_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];

  // Pointers wrap naturally at DEPTH; reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is not reset; consumers mask the head while empty.
  always_ff @(posedge clk) begin
    if (rst_n && do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/rvc_decompressor.sv
// RV32C parcel expander: maps a 16-bit compressed parcel to its 32-bit RV32I equivalent.
module rvc_decompressor (
  input  logic [15:0] parcel,
  output logic [31:0] instruction,
  output logic        is_compressed,
  output logic        illegal
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;

  logic [4:0] rd_s;
  logic [4:0] rs2_s;
  logic [4:0] rdc_s;
  logic [4:0] rs2c_s;

  assign rd_s          = parcel[11:7];
  assign rs2_s         = parcel[6:2];
  assign rdc_s         = {2'b01, parcel[9:7]};
  assign rs2c_s        = {2'b01, parcel[4:2]};
  assign is_compressed = (parcel[1:0] != 2'b11);

  // Quadrant/funct3 expansion; FP and RV64-only encodings are reported illegal.
  always_comb begin
    instruction = {16'h0000, parcel};
    illegal     = 1'b0;
    case (parcel[1:0])
      2'b00: begin
        case (parcel[15:13])
          3'b000: begin
            instruction = {2'b00, parcel[10:7], parcel[12:11], parcel[5], parcel[6], 2'b00,
                           5'd2, 3'b000, rs2c_s, OP_IMM};
            illegal     = (parcel[12:5] == 8'h00);
          end
          3'b010: instruction = {5'b00000, parcel[5], parcel[12:10], parcel[6], 2'b00,
                                 rdc_s, 3'b010, rs2c_s, LOAD};
          3'b110: instruction = {5'b00000, parcel[5], parcel[12], rs2c_s, rdc_s, 3'b010,
                                 parcel[11:10], parcel[6], 2'b00, STORE};
          default: illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (parcel[15:13])
          3'b000: instruction = {{7{parcel[12]}}, rs2_s, rd_s, 3'b000, rd_s, OP_IMM};
          3'b001: instruction = {parcel[12], parcel[8], parcel[10:9], parcel[6], parcel[7],
                                 parcel[2], parcel[11], parcel[5:3], parcel[12],
                                 {8{parcel[12]}}, 5'd1, JAL};
          3'b010: instruction = {{7{parcel[12]}}, rs2_s, 5'd0, 3'b000, rd_s, OP_IMM};
          3'b011: begin
            illegal = ({parcel[12], rs2_s} == 6'd0);
            if (rd_s == 5'd2) begin
              instruction = {{3{parcel[12]}}, parcel[4:3], parcel[5], parcel[2], parcel[6],
                             4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              instruction = {{15{parcel[12]}}, rs2_s, rd_s, LUI};
            end
          end
          3'b100: begin
            case (parcel[11:10])
              2'b00: begin
                instruction = {7'b0000000, rs2_s, rdc_s, 3'b101, rdc_s, OP_IMM};
                illegal     = parcel[12];
              end
              2'b01: begin
                instruction = {7'b0100000, rs2_s, rdc_s, 3'b101, rdc_s, OP_IMM};
                illegal     = parcel[12];
              end
              2'b10: instruction = {{7{parcel[12]}}, rs2_s, rdc_s, 3'b111, rdc_s, OP_IMM};
              default: begin
                if (parcel[12]) begin
                  illegal = 1'b1;
                end else begin
                  case (parcel[6:5])
                    2'b00:   instruction = {7'b0100000, rs2c_s, rdc_s, 3'b000, rdc_s, OP};
                    2'b01:   instruction = {7'b0000000, rs2c_s, rdc_s, 3'b100, rdc_s, OP};
                    2'b10:   instruction = {7'b0000000, rs2c_s, rdc_s, 3'b110, rdc_s, OP};
                    default: instruction = {7'b0000000, rs2c_s, rdc_s, 3'b111, rdc_s, OP};
                  endcase
                end
              end
            endcase
          end
          3'b101: instruction = {parcel[12], parcel[8], parcel[10:9], parcel[6], parcel[7],
                                 parcel[2], parcel[11], parcel[5:3], parcel[12],
                                 {8{parcel[12]}}, 5'd0, JAL};
          3'b110: instruction = {parcel[12], {3{parcel[12]}}, parcel[6:5], parcel[2], 5'd0,
                                 rdc_s, 3'b000, parcel[11:10], parcel[4:3], parcel[12], BRANCH};
          default: instruction = {parcel[12], {3{parcel[12]}}, parcel[6:5], parcel[2], 5'd0,
                                  rdc_s, 3'b001, parcel[11:10], parcel[4:3], parcel[12], BRANCH};
        endcase
      end
      2'b10: begin
        case (parcel[15:13])
          3'b000: begin
            instruction = {7'b0000000, rs2_s, rd_s, 3'b001, rd_s, OP_IMM};
            illegal     = parcel[12];
          end
          3'b010: begin
            instruction = {4'b0000, parcel[3:2], parcel[12], parcel[6:4], 2'b00,
                           5'd2, 3'b010, rd_s, LOAD};
            illegal     = (rd_s == 5'd0);
          end
          3'b100: begin
            if (!parcel[12]) begin
              if (rs2_s == 5'd0) begin
                instruction = {12'h000, rd_s, 3'b000, 5'd0, JALR};
                illegal     = (rd_s == 5'd0);
              end else begin
                instruction = {7'b0000000, rs2_s, 5'd0, 3'b000, rd_s, OP};
              end
            end else if (rs2_s == 5'd0) begin
              if (rd_s == 5'd0) begin
                instruction = 32'h0010_0073;
              end else begin
                instruction = {12'h000, rd_s, 3'b000, 5'd1, JALR};
              end
            end else begin
              instruction = {7'b0000000, rs2_s, rd_s, 3'b000, rd_s, OP};
            end
          end
          3'b110: instruction = {4'b0000, parcel[8:7], parcel[12], rs2_s, 5'd2, 3'b010,
                                 parcel[11:9], 2'b00, STORE};
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pd_decode_queue.sv
// Pre-decode stage: selects/decompresses the instruction and queues entries between IF and ID.
// Build option PD_DECODE_QUEUE_RVC_EN builds the RVC expander; without it RVC entries become illegal NOPs.
module pd_decode_queue
  import riscv_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  DEPTH  = 4,
  parameter int  META_W = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [15:0]       i_raw_parcel,
  input  logic [31:0]       i_spanning_instr,
  input  logic [31:0]       i_effective_instr,
  input  logic              i_sel_spanning,
  input  logic              i_sel_compressed,
  input  logic              i_sel_nop,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_link_address,
  input  logic [META_W-1:0] i_meta,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instruction,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_link_address,
  output logic [4:0]        o_rs1_early,
  output logic [4:0]        o_rs2_early,
  output logic [4:0]        o_rs3_early,
  output logic              o_illegal,
  output logic [META_W-1:0] o_meta,
  output logic [CNT_W-1:0]  o_count
);

  // Same layout as pd_queue_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [31:0]       instruction;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   link_address;
    logic              illegal;
    logic [META_W-1:0] meta;
  } entry_t;

  logic [31:0] rvc_instr_s;
  logic        rvc_is_comp_s;
  logic        rvc_illegal_s;
  entry_t      wr_entry_s;
  entry_t      rd_entry_s;
  entry_t      head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        pop_s;

`ifdef PD_DECODE_QUEUE_RVC_EN
  rvc_decompressor u_rvc (
    .parcel        (i_raw_parcel),
    .instruction   (rvc_instr_s),
    .is_compressed (rvc_is_comp_s),
    .illegal       (rvc_illegal_s)
  );
`else
  logic unused_parcel_s;
  assign unused_parcel_s = ^i_raw_parcel;
  assign rvc_instr_s     = NOP_INSTR;
  assign rvc_is_comp_s   = 1'b1;
  assign rvc_illegal_s   = 1'b1;
`endif

  assign o_ready = !fifo_full_s;
  assign o_valid = !fifo_empty_s;
  assign push_s  = i_valid && o_ready && !i_sel_nop && !i_flush;
  assign pop_s   = o_valid && i_ready && !i_flush;

  // Instruction selection ahead of the storage write; nop entries never reach here as pushes.
  always_comb begin
    wr_entry_s              = '0;
    wr_entry_s.pc           = i_pc;
    wr_entry_s.link_address = i_link_address;
    wr_entry_s.meta         = i_meta;
    if (i_sel_spanning) begin
      wr_entry_s.instruction = i_spanning_instr;
      wr_entry_s.illegal     = 1'b0;
    end else if (i_sel_compressed) begin
      wr_entry_s.instruction = rvc_instr_s;
      wr_entry_s.illegal     = rvc_is_comp_s && rvc_illegal_s;
    end else begin
      wr_entry_s.instruction = i_effective_instr;
      wr_entry_s.illegal     = 1'b0;
    end
  end

  pd_queue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .flush   (i_flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_entry_s),
    .rd_data (rd_entry_s),
    .count   (o_count),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Present a clean NOP head while empty so stale storage never leaks downstream.
  always_comb begin
    head_s = rd_entry_s;
    if (fifo_empty_s) begin
      head_s             = '0;
      head_s.instruction = NOP_INSTR;
    end else begin
      head_s = rd_entry_s;
    end
  end

  assign o_instruction  = head_s.instruction;
  assign o_pc           = head_s.pc;
  assign o_link_address = head_s.link_address;
  assign o_illegal      = head_s.illegal;
  assign o_meta         = head_s.meta;
  assign o_rs1_early    = head_s.instruction[19:15];
  assign o_rs2_early    = head_s.instruction[24:20];
  assign o_rs3_early    = head_s.instruction[31:27];

endmodule

// File: tb/tb_pd_decode_queue.sv
// Self-checking bench for pd_decode_queue: directed scenarios plus randomized traffic against a queue model.
module tb_pd_decode_queue;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int META_W = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              i_rst_n, i_flush, i_valid, o_ready;
  logic [15:0]       i_raw_parcel;
  logic [31:0]       i_spanning_instr, i_effective_instr;
  logic              i_sel_spanning, i_sel_compressed, i_sel_nop;
  logic [XLEN-1:0]   i_pc, i_link_address;
  logic [META_W-1:0] i_meta;
  logic              o_valid, i_ready;
  logic [31:0]       o_instruction;
  logic [XLEN-1:0]   o_pc, o_link_address;
  logic [4:0]        o_rs1_early, o_rs2_early, o_rs3_early;
  logic              o_illegal;
  logic [META_W-1:0] o_meta;
  logic [CNT_W-1:0]  o_count;

  pd_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .META_W(META_W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_raw_parcel(i_raw_parcel), .i_spanning_instr(i_spanning_instr),
    .i_effective_instr(i_effective_instr), .i_sel_spanning(i_sel_spanning),
    .i_sel_compressed(i_sel_compressed), .i_sel_nop(i_sel_nop), .i_pc(i_pc),
    .i_link_address(i_link_address), .i_meta(i_meta), .o_valid(o_valid), .i_ready(i_ready),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_link_address(o_link_address),
    .o_rs1_early(o_rs1_early), .o_rs2_early(o_rs2_early), .o_rs3_early(o_rs3_early),
    .o_illegal(o_illegal), .o_meta(o_meta), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   link;
    logic              illegal;
    logic [META_W-1:0] meta;
  } exp_t;

  exp_t model_q[$];
  int   passed = 0;
  int   total  = 0;

  // Known RV32C expansions used by the model when the expander is built.
  logic [15:0] rvc_parcel [4] = '{16'h0405, 16'h4501, 16'h8082, 16'h4585};
  logic [31:0] rvc_expand [4] = '{32'h0014_0413, 32'h0000_0513, 32'h0000_8067, 32'h0010_0593};

  task automatic idle_inputs();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_raw_parcel = 16'h0000; i_spanning_instr = 32'h0; i_effective_instr = 32'h0;
    i_sel_spanning = 1'b0; i_sel_compressed = 1'b0; i_sel_nop = 1'b0;
    i_pc = '0; i_link_address = '0; i_meta = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  function automatic exp_t expect_entry();
    exp_t e;
    e.pc = i_pc; e.link = i_link_address; e.meta = i_meta;
    if (i_sel_spanning) begin
      e.instr = i_spanning_instr; e.illegal = 1'b0;
    end else if (i_sel_compressed) begin
      e.instr = NOP; e.illegal = 1'b1;
`ifdef PD_DECODE_QUEUE_RVC_EN
      for (int k = 0; k < 4; k++)
        if (rvc_parcel[k] == i_raw_parcel) begin e.instr = rvc_expand[k]; e.illegal = 1'b0; end
`endif
    end else begin
      e.instr = i_effective_instr; e.illegal = 1'b0;
    end
    return e;
  endfunction

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0; i_valid = 1'b1; i_effective_instr = 32'hDEAD_BEEF; i_pc = 32'h1234;
    tick();
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passed++;
    total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else passed++;
    total++; if (o_count !== CNT_W'(0)) $display("FAIL reset_count: got %0d want 0", o_count); else passed++;
    total++; if (o_instruction !== NOP) $display("FAIL reset_instr: got %h want %h", o_instruction, NOP); else passed++;
    total++; if (o_pc !== '0 || o_link_address !== '0 || o_meta !== '0 || o_illegal !== 1'b0)
      $display("FAIL reset_head: pc %h link %h meta %h ill %b want all 0", o_pc, o_link_address, o_meta, o_illegal);
    else passed++;
    i_rst_n = 1'b1; i_valid = 1'b0;
    tick();
    total++; if (o_count !== CNT_W'(0)) $display("FAIL reset_release_count: got %0d want 0", o_count); else passed++;
  endtask

  task automatic test_compressed();
    logic [31:0] exp_instr;
    logic [4:0]  exp_rs1;
    logic        exp_ill;
`ifdef PD_DECODE_QUEUE_RVC_EN
    exp_instr = 32'h0014_0413; exp_rs1 = 5'd8; exp_ill = 1'b0;
`else
    exp_instr = NOP; exp_rs1 = 5'd0; exp_ill = 1'b1;
`endif
    do_reset();
    i_valid = 1'b1; i_sel_compressed = 1'b1; i_raw_parcel = 16'h0405; i_pc = 32'h0000_0100;
    tick();
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b1) $display("FAIL cmp_valid: got %b want 1", o_valid); else passed++;
    total++; if (o_count !== CNT_W'(1)) $display("FAIL cmp_count: got %0d want 1", o_count); else passed++;
    total++; if (o_instruction !== exp_instr) $display("FAIL cmp_instr: got %h want %h", o_instruction, exp_instr); else passed++;
    total++; if (o_rs1_early !== exp_rs1) $display("FAIL cmp_rs1: got %0d want %0d", o_rs1_early, exp_rs1); else passed++;
    total++; if (o_illegal !== exp_ill) $display("FAIL cmp_illegal: got %b want %b", o_illegal, exp_ill); else passed++;
    total++; if (o_pc !== 32'h0000_0100) $display("FAIL cmp_pc: got %h want 100", o_pc); else passed++;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0) $display("FAIL cmp_drain: got %b want 0", o_valid); else passed++;
    i_valid = 1'b1; i_raw_parcel = 16'h0000;
    tick();
    i_valid = 1'b0;
    total++; if (o_illegal !== 1'b1) $display("FAIL zero_parcel_illegal: got %b want 1", o_illegal); else passed++;
`ifndef PD_DECODE_QUEUE_RVC_EN
    total++; if (o_instruction !== NOP) $display("FAIL zero_parcel_instr: got %h want %h", o_instruction, NOP); else passed++;
`endif
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0; i_valid = 1'b1; i_sel_spanning = 1'b1; i_spanning_instr = 32'h1234_5678;
    i_effective_instr = 32'h0BAD_0BAD;
    tick();
    i_valid = 1'b0;
    total++; if (o_instruction !== 32'h1234_5678 || o_illegal !== 1'b0)
      $display("FAIL spanning_prio: got %h/%b want 12345678/0", o_instruction, o_illegal);
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_effective_instr = 32'hA000_0000 | k;
      tick();
      total++; if (o_count !== CNT_W'((k + 1 > DEPTH) ? DEPTH : k + 1))
        $display("FAIL full_count[%0d]: got %0d want %0d", k, o_count, (k + 1 > DEPTH) ? DEPTH : k + 1);
      else passed++;
      total++; if (o_ready !== (k + 1 < DEPTH))
        $display("FAIL full_ready[%0d]: got %b want %b", k, o_ready, (k + 1 < DEPTH));
      else passed++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      total++; if (o_instruction !== (32'hA000_0000 | k))
        $display("FAIL drain_order[%0d]: got %h want %h", k, o_instruction, 32'hA000_0000 | k);
      else passed++;
      tick();
    end
    total++; if (o_valid !== 1'b0 || o_instruction !== NOP)
      $display("FAIL drain_empty: valid %b instr %h want 0/%h", o_valid, o_instruction, NOP);
    else passed++;
  endtask

  task automatic test_nop();
    do_reset();
    i_valid = 1'b1; i_sel_nop = 1'b1; i_effective_instr = 32'h1111_1111;
    total++; if (o_ready !== 1'b1) $display("FAIL nop_ready: got %b want 1", o_ready); else passed++;
    tick();
    total++; if (o_count !== CNT_W'(0) || o_valid !== 1'b0)
      $display("FAIL nop_dropped: count %0d valid %b want 0/0", o_count, o_valid);
    else passed++;
    i_sel_nop = 1'b0;
    tick();
    i_sel_nop = 1'b1; i_sel_spanning = 1'b1;
    tick();
    i_valid = 1'b0;
    total++; if (o_count !== CNT_W'(1) || o_instruction !== 32'h1111_1111)
      $display("FAIL nop_after_push: count %0d instr %h want 1/11111111", o_count, o_instruction);
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_effective_instr = 32'hC000_0000 | k;
      tick();
    end
    total++; if (o_count !== CNT_W'(3)) $display("FAIL flush_fill: got %0d want 3", o_count); else passed++;
    i_flush = 1'b1; i_ready = 1'b1; i_effective_instr = 32'hC000_00FF;
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    total++; if (o_count !== CNT_W'(0) || o_valid !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL flush_state: count %0d valid %b ready %b want 0/0/1", o_count, o_valid, o_ready);
    else passed++;
    total++; if (o_instruction !== NOP) $display("FAIL flush_instr: got %h want %h", o_instruction, NOP); else passed++;
    tick();
    total++; if (o_count !== CNT_W'(0)) $display("FAIL flush_no_push: got %0d want 0", o_count); else passed++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    i_valid = 1'b1; i_effective_instr = 32'hE000_0001;
    tick();
    tick();
    i_rst_n = 1'b0; i_flush = 1'b1;
    tick();
    i_rst_n = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
    total++; if (o_count !== CNT_W'(0) || o_valid !== 1'b0)
      $display("FAIL reset_midop: count %0d valid %b want 0/0", o_count, o_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1; i_effective_instr = 32'hB000_0000 + k;
      tick();
    end
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      total++; if (o_instruction !== 32'hB000_0000 + k)
        $display("FAIL b2b_order[%0d]: got %h want %h", k, o_instruction, 32'hB000_0000 + k);
      else passed++;
      i_effective_instr = 32'hB000_0000 + k + 2;
      tick();
      total++; if (o_count !== CNT_W'(2)) $display("FAIL b2b_count[%0d]: got %0d want 2", k, o_count); else passed++;
    end
    total++; if (o_instruction !== 32'hB000_0014)
      $display("FAIL b2b_final: got %h want b0000014", o_instruction);
    else passed++;
  endtask

  task automatic test_random();
    exp_t h;
    exp_t e;
    logic push_m, pop_m;
    int   idx;
    do_reset();
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      idx = $urandom_range(3);
      i_flush          = ($urandom_range(15) == 0);
      i_valid          = ($urandom_range(3) != 0);
      i_ready          = ($urandom_range(1) == 1);
      i_sel_nop        = ($urandom_range(7) == 0);
      i_sel_spanning   = ($urandom_range(3) == 0);
      i_sel_compressed = ($urandom_range(2) == 0);
      i_raw_parcel     = rvc_parcel[idx];
      i_spanning_instr = $urandom; i_effective_instr = $urandom;
      i_pc = $urandom; i_link_address = $urandom; i_meta = {$urandom, $urandom};
      push_m = i_valid && (model_q.size() < DEPTH) && !i_sel_nop && !i_flush;
      pop_m  = (model_q.size() != 0) && i_ready && !i_flush;
      e = expect_entry();
      if (i_flush) model_q.delete();
      else begin
        if (pop_m)  void'(model_q.pop_front());
        if (push_m) model_q.push_back(e);
      end
      tick();
      if (model_q.size() != 0) h = model_q[0];
      else begin h.instr = NOP; h.pc = '0; h.link = '0; h.illegal = 1'b0; h.meta = '0; end
      total++; if (o_valid !== (model_q.size() != 0)) $display("FAIL rnd_valid c%0d: got %b want %b", c, o_valid, model_q.size() != 0); else passed++;
      total++; if (o_ready !== (model_q.size() < DEPTH)) $display("FAIL rnd_ready c%0d: got %b want %b", c, o_ready, model_q.size() < DEPTH); else passed++;
      total++; if (o_count !== CNT_W'(model_q.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, o_count, model_q.size()); else passed++;
      total++; if (o_instruction !== h.instr) $display("FAIL rnd_instr c%0d: got %h want %h", c, o_instruction, h.instr); else passed++;
      total++; if (o_rs1_early !== h.instr[19:15] || o_rs2_early !== h.instr[24:20] || o_rs3_early !== h.instr[31:27])
        $display("FAIL rnd_rs c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, o_rs1_early, o_rs2_early, o_rs3_early,
                 h.instr[19:15], h.instr[24:20], h.instr[31:27]);
      else passed++;
      total++; if (o_pc !== h.pc || o_link_address !== h.link)
        $display("FAIL rnd_pc c%0d: got %h/%h want %h/%h", c, o_pc, o_link_address, h.pc, h.link);
      else passed++;
      total++; if (o_illegal !== h.illegal) $display("FAIL rnd_illegal c%0d: got %b want %b", c, o_illegal, h.illegal); else passed++;
      total++; if (o_meta !== h.meta) $display("FAIL rnd_meta c%0d: got %h want %h", c, o_meta, h.meta); else passed++;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_compressed();
    test_full();
    test_nop();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
